// File: rtl/hptdc_pkg.sv
// Shared definitions for the HPTDC readout path: packet codes, FSM encoding
// and the bit layout of header/trailer words.
package hptdc_pkg;

    localparam logic [3:0] HDR_CODE = 4'hA;
    localparam logic [3:0] TRL_CODE = 4'hC;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_READ    = 3'd2,
        ST_WAIT    = 3'd3,
        ST_SEND    = 3'd4,
        ST_TRAILER = 3'd5
    } state_t;

    // Packet field positions (header: code|board|pkt_count, trailer: code|nwords|checksum)
    localparam int CODE_MSB = 31;
    localparam int CODE_LSB = 28;
    localparam int MID_MSB  = 27;
    localparam int MID_LSB  = 16;
    localparam int LOW_MSB  = 15;
    localparam int LOW_LSB  = 0;

    function automatic logic [31:0] make_header(input logic [11:0] board_id,
                                                input logic [15:0] count);
        logic [31:0] w;
        w                    = '0;
        w[CODE_MSB:CODE_LSB] = HDR_CODE;
        w[MID_MSB:MID_LSB]   = board_id;
        w[LOW_MSB:LOW_LSB]   = count;
        return w;
    endfunction

    function automatic logic [31:0] make_trailer(input logic [11:0] nwords,
                                                 input logic [15:0] csum);
        logic [31:0] w;
        w                    = '0;
        w[CODE_MSB:CODE_LSB] = TRL_CODE;
        w[MID_MSB:MID_LSB]   = nwords;
        w[LOW_MSB:LOW_LSB]   = csum;
        return w;
    endfunction

endpackage

// File: rtl/hptdc_event_packer.sv
// Drains the HPTDC measurement FIFO one word at a time and frames each burst
// as header / data words / trailer on a valid-ready stream.
module hptdc_event_packer
    import hptdc_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          MAX_WORDS  = 255,
    parameter logic [11:0] BOARD_ID   = 12'h000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_data_valid,
    output logic                  fifo_read_enable,
    output logic [DATA_WIDTH-1:0] pkt_data,
    output logic                  pkt_valid,
    input  logic                  pkt_ready,
    output logic                  pkt_sop,
    output logic                  pkt_eop,
    output logic [15:0]           pkt_count,
    output logic                  busy,
    output state_t                dbg_state
);

    // Stream: a word transfers on a cycle where pkt_valid & pkt_ready; while
    // pkt_valid & !pkt_ready, pkt_data/sop/eop hold and pkt_valid stays high.

    localparam logic [11:0] MAX_W = 12'(MAX_WORDS);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_pkt_data;
    logic [DATA_WIDTH-1:0] w_pkt_data_nxt;
    logic [11:0]           r_word_cnt;
    logic [11:0]           w_word_cnt_nxt;
    logic [15:0]           r_csum;
    logic [15:0]           w_csum_nxt;
    logic [15:0]           r_pkt_count;
    logic [15:0]           w_pkt_count_nxt;
    logic                  w_hs;
    logic [11:0]           w_cnt_inc;
    logic [15:0]           w_csum_upd;

    assign w_hs       = pkt_valid & pkt_ready;
    assign w_cnt_inc  = r_word_cnt + 12'd1;
    assign w_csum_upd = r_csum ^ r_pkt_data[31:16] ^ r_pkt_data[15:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pkt_data  <= '0;
            r_word_cnt  <= '0;
            r_csum      <= '0;
            r_pkt_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pkt_data  <= w_pkt_data_nxt;
            r_word_cnt  <= w_word_cnt_nxt;
            r_csum      <= w_csum_nxt;
            r_pkt_count <= w_pkt_count_nxt;
        end
    end

    // The output word register is loaded on the transition into each
    // presenting state, so pkt_data never depends combinationally on pkt_ready.
    always_comb begin
        w_state_nxt     = r_state;
        w_pkt_data_nxt  = r_pkt_data;
        w_word_cnt_nxt  = r_word_cnt;
        w_csum_nxt      = r_csum;
        w_pkt_count_nxt = r_pkt_count;
        case (r_state)
            ST_IDLE: begin
                if (enable && !fifo_empty) begin
                    w_state_nxt    = ST_HEADER;
                    w_pkt_data_nxt = make_header(BOARD_ID, r_pkt_count);
                end
            end
            ST_HEADER: begin
                if (w_hs) w_state_nxt = ST_READ;
            end
            ST_READ: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (fifo_data_valid) begin
                    w_state_nxt    = ST_SEND;
                    w_pkt_data_nxt = fifo_data;
                end else if (fifo_empty) begin
                    w_state_nxt    = ST_TRAILER;
                    w_pkt_data_nxt = make_trailer(r_word_cnt, r_csum);
                end else begin
                    // read was dropped by a colliding FIFO write; try again
                    w_state_nxt = ST_READ;
                end
            end
            ST_SEND: begin
                if (w_hs) begin
                    w_word_cnt_nxt = w_cnt_inc;
                    w_csum_nxt     = w_csum_upd;
                    if (w_cnt_inc == MAX_W || fifo_empty) begin
                        w_state_nxt    = ST_TRAILER;
                        w_pkt_data_nxt = make_trailer(w_cnt_inc, w_csum_upd);
                    end else begin
                        w_state_nxt = ST_READ;
                    end
                end
            end
            ST_TRAILER: begin
                if (w_hs) begin
                    w_state_nxt     = ST_IDLE;
                    w_pkt_count_nxt = r_pkt_count + 16'd1;
                    w_word_cnt_nxt  = '0;
                    w_csum_nxt      = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign pkt_valid        = (r_state == ST_HEADER) || (r_state == ST_SEND) ||
                              (r_state == ST_TRAILER);
    assign pkt_sop          = (r_state == ST_HEADER);
    assign pkt_eop          = (r_state == ST_TRAILER);
    assign fifo_read_enable = (r_state == ST_READ);
    assign busy             = (r_state != ST_IDLE);
    assign pkt_data         = r_pkt_data;
    assign pkt_count        = r_pkt_count;
    assign dbg_state        = r_state;

endmodule

// File: tb/tb_hptdc_event_packer.sv
// Directed bench for hptdc_event_packer: behavioural FIFO, expected-word
// scoreboard, table-driven 3-word packet plus multi-cycle corner sequences.
module tb_hptdc_event_packer;
    import hptdc_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_data = '0;
    logic        fifo_data_valid = 1'b0;
    logic        fifo_read_enable;
    logic [31:0] pkt_data;
    logic        pkt_valid;
    logic        pkt_ready = 1'b1;
    logic        pkt_sop;
    logic        pkt_eop;
    logic [15:0] pkt_count;
    logic        busy;
    state_t      dbg_state;

    always #5 clk = ~clk;

    hptdc_event_packer #(.DATA_WIDTH(32), .MAX_WORDS(255), .BOARD_ID(12'h000)) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .fifo_empty       (fifo_empty),
        .fifo_data        (fifo_data),
        .fifo_data_valid  (fifo_data_valid),
        .fifo_read_enable (fifo_read_enable),
        .pkt_data         (pkt_data),
        .pkt_valid        (pkt_valid),
        .pkt_ready        (pkt_ready),
        .pkt_sop          (pkt_sop),
        .pkt_eop          (pkt_eop),
        .pkt_count        (pkt_count),
        .busy             (busy),
        .dbg_state        (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int          n_vec = 0;
    int          n_fail = 0;
    logic [33:0] exp_q[$];      // {sop, eop, data}
    logic [31:0] fifo_q[$];
    int          n_reads = 0;
    int          drop_req = 0;
    int          drop_ack = 0;
    bit          rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural FIFO ----------------
    always @(posedge clk) begin
        fifo_data_valid <= 1'b0;
        if (fifo_read_enable) begin
            n_reads <= n_reads + 1;
            if (drop_req != drop_ack) begin
                drop_ack <= drop_ack + 1;
            end else if (fifo_q.size() != 0) begin
                fifo_data       <= fifo_q.pop_front();
                fifo_data_valid <= 1'b1;
            end
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    // ---------------- sink ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            pkt_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- scoreboard / stream monitor ----------------
    logic        prev_stall = 1'b0;
    logic [33:0] prev_word = '0;
    logic [33:0] exp_w;

    always @(negedge clk) begin
        if (!rst) begin
            if (pkt_valid && pkt_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %h expected none", {pkt_sop, pkt_eop, pkt_data});
                end else begin
                    exp_w = exp_q.pop_front();
                    check("pkt_word", {pkt_sop, pkt_eop, pkt_data}, exp_w);
                end
            end
            if (prev_stall)
                check("stall_stable", {pkt_valid, pkt_sop, pkt_eop, pkt_data}, {1'b1, prev_word});
            if (fifo_data_valid)
                check("dv_outside_wait", dbg_state, ST_WAIT);
            prev_stall = pkt_valid && !pkt_ready;
            prev_word  = {pkt_sop, pkt_eop, pkt_data};
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        fifo_push;
        logic [31:0] fifo_word;
        logic [31:0] exp_word;
        logic        exp_sop;
        logic        exp_eop;
    } vec_t;

    vec_t t1[5];

    task automatic apply_table(input logic [15:0] hdr_cnt);
        foreach (t1[i]) begin
            if (t1[i].fifo_push) fifo_q.push_back(t1[i].fifo_word);
            exp_q.push_back({t1[i].exp_sop, t1[i].exp_eop,
                             t1[i].exp_sop ? (t1[i].exp_word | {16'h0, hdr_cnt}) : t1[i].exp_word});
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && dbg_state == ST_IDLE) break;
        end
        check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic start_packing();
        @(posedge clk);
        #1;
        enable = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    int          reads0;
    logic [31:0] w;
    logic [15:0] cs;
    bit          found;

    initial begin
        t1[0] = '{fifo_push: 1'b0, fifo_word: 32'h0,         exp_word: 32'hA000_0000, exp_sop: 1'b1, exp_eop: 1'b0};
        t1[1] = '{fifo_push: 1'b1, fifo_word: 32'h4000_0001, exp_word: 32'h4000_0001, exp_sop: 1'b0, exp_eop: 1'b0};
        t1[2] = '{fifo_push: 1'b1, fifo_word: 32'h4000_0002, exp_word: 32'h4000_0002, exp_sop: 1'b0, exp_eop: 1'b0};
        t1[3] = '{fifo_push: 1'b1, fifo_word: 32'h4000_0003, exp_word: 32'h4000_0003, exp_sop: 1'b0, exp_eop: 1'b0};
        t1[4] = '{fifo_push: 1'b0, fifo_word: 32'h0,         exp_word: 32'hC003_4000, exp_sop: 1'b0, exp_eop: 1'b1};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", pkt_valid, 1'b0);
        check("rst_data", pkt_data, 32'h0);
        check("rst_sop_eop", {pkt_sop, pkt_eop}, 2'b00);
        check("rst_read", fifo_read_enable, 1'b0);
        check("rst_count", pkt_count, 16'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_state", dbg_state, ST_IDLE);
        @(posedge clk);
        #1 rst = 1'b0;

        // basic 3-word packet
        apply_table(16'd0);
        reads0 = n_reads;
        start_packing();
        wait_drain("t1", 200);
        enable = 1'b0;
        check("t1_count", pkt_count, 16'd1);
        check("t1_reads", 64'(n_reads - reads0), 64'd3);

        // same packet under random backpressure
        rand_ready = 1'b1;
        apply_table(16'd1);
        start_packing();
        wait_drain("t3", 400);
        enable = 1'b0;
        rand_ready = 1'b0;
        check("t3_count", pkt_count, 16'd2);

        // one read swallowed by a colliding write: retry, nothing lost
        drop_req = drop_req + 1;
        apply_table(16'd2);
        reads0 = n_reads;
        start_packing();
        wait_drain("t4", 200);
        enable = 1'b0;
        check("t4_count", pkt_count, 16'd3);
        check("t4_reads", 64'(n_reads - reads0), 64'd4);

        // 300 words split at MAX_WORDS, from a fresh reset
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("t2_count_after_rst", pkt_count, 16'd0);
        exp_q.push_back({2'b10, 32'hA000_0000});
        cs = '0;
        for (int i = 0; i < 300; i++) begin
            w = 32'h8000_0000 | 32'(i);
            fifo_q.push_back(w);
            exp_q.push_back({2'b00, w});
            cs = cs ^ w[31:16] ^ w[15:0];
            if (i == 254) begin
                exp_q.push_back({2'b01, 4'hC, 12'h0FF, cs});
                exp_q.push_back({2'b10, 32'hA000_0001});
                cs = '0;
            end
        end
        exp_q.push_back({2'b01, 4'hC, 12'h02D, cs});
        start_packing();
        wait_drain("t2", 3000);
        enable = 1'b0;
        check("t2_count", pkt_count, 16'd2);

        // enable low holds off packing even with data waiting
        fifo_q.push_back(32'h0BAD_F00D);
        fifo_q.push_back(32'h1234_5678);
        cs = 16'h0BAD ^ 16'hF00D ^ 16'h1234 ^ 16'h5678;
        exp_q.push_back({2'b10, 32'hA000_0002});
        exp_q.push_back({2'b00, 32'h0BAD_F00D});
        exp_q.push_back({2'b00, 32'h1234_5678});
        exp_q.push_back({2'b01, 4'hC, 12'h002, cs});
        repeat (2) @(posedge clk);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t6_idle_busy", busy, 1'b0);
            check("t6_idle_read", fifo_read_enable, 1'b0);
        end
        @(posedge clk);
        #1 enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_header_next_cycle", {pkt_valid, pkt_sop}, 2'b11);
        wait_drain("t6", 200);
        check("t6_count", pkt_count, 16'd3);

        // reset during SEND of the second word
        fifo_q.push_back(32'h1111_2222);
        fifo_q.push_back(32'h3333_4444);
        fifo_q.push_back(32'h5555_6666);
        fifo_q.push_back(32'h7777_8888);
        exp_q.push_back({2'b10, 32'hA000_0003});
        exp_q.push_back({2'b00, 32'h1111_2222});
        exp_q.push_back({2'b00, 32'h3333_4444});
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (dbg_state == ST_SEND && pkt_data == 32'h3333_4444) begin
                found = 1'b1;
                break;
            end
        end
        check("t5_reach_send2", found, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_valid", pkt_valid, 1'b0);
        check("t5_rst_data", pkt_data, 32'h0);
        check("t5_rst_sop_eop", {pkt_sop, pkt_eop}, 2'b00);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_read", fifo_read_enable, 1'b0);
        check("t5_rst_count", pkt_count, 16'h0);
        exp_q.delete();
        cs = 16'h5555 ^ 16'h6666 ^ 16'h7777 ^ 16'h8888;
        exp_q.push_back({2'b10, 32'hA000_0000});
        exp_q.push_back({2'b00, 32'h5555_6666});
        exp_q.push_back({2'b00, 32'h7777_8888});
        exp_q.push_back({2'b01, 4'hC, 12'h002, cs});
        @(posedge clk);
        #1 rst = 1'b0;
        wait_drain("t5", 200);
        enable = 1'b0;
        check("t5_count", pkt_count, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // hard time limit
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
